// File: rtl/or_gate_exerciser.sv
// Stimulus/capture wrapper for an or_gate_bit: sweeps every {a,b} vector,
// checks y against a|b and reports pass, error count and first failing index.
module or_gate_exerciser #(
  parameter  int WIDTH  = 1,
  parameter  int SETTLE = 1,
  localparam int IW     = 2 * WIDTH,
  localparam int N      = 2 ** IW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [IW:0]      err_count,
  output logic [IW-1:0]    first_fail
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [IW:0]   ERR_ONE  = (IW + 1)'(1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   idx_nxt;
  logic            mismatch;

  assign idx_nxt  = idx + IDX_ONE;
  assign mismatch = (y != (a | b));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      idx        <= '0;
      a          <= '0;
      b          <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      first_fail <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          a    <= '0;
          b    <= '0;
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            idx        <= '0;
            cnt        <= '0;
            err_count  <= '0;
            first_fail <= '0;
            pass       <= 1'b0;
            busy       <= 1'b1;
            state      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          // counter restarts per vector so each one gets SETTLE cycles here
          if (cnt == CNT_LAST) begin
            state <= S_CHECK;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_CHECK: begin
          if (mismatch) begin
            err_count <= err_count + ERR_ONE;
            if (err_count == '0) begin
              first_fail <= idx;
            end
          end
          if (idx == IDX_LAST) begin
            a     <= '0;
            b     <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            idx    <= idx_nxt;
            {a, b} <= idx_nxt;
            cnt    <= '0;
            state  <= S_SETTLE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          pass  <= (err_count == '0);
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_or_gate_exerciser.sv
// Bench for or_gate_exerciser: directed fault cases plus random
// corruption tables, checked against a per-vector reference model.
module tb_or_gate_exerciser;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start1 = 1'b0;
  logic start2 = 1'b0;

  logic       a1, b1, y1, busy1, done1, pass1;
  logic [2:0] err1;
  logic [1:0] ff1;
  logic [1:0] a2, b2, y2;
  logic       busy2, done2, pass2;
  logic [4:0] err2;
  logic [3:0] ff2;

  int mode1 = 0;
  int mode2 = 0;
  int cur_sel = 0;
  int n_assert = 0;
  int n_fail = 0;
  logic [3:0] corrupt [256];

  always #5 clk = ~clk;

  or_gate_exerciser #(.WIDTH(1), .SETTLE(1)) u1 (
    .clk(clk), .reset(reset), .start(start1),
    .a(a1), .b(b1), .y(y1),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_fail(ff1)
  );

  or_gate_exerciser #(.WIDTH(2), .SETTLE(3)) u2 (
    .clk(clk), .reset(reset), .start(start2),
    .a(a2), .b(b2), .y(y2),
    .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .first_fail(ff2)
  );

  // gate under test, with optional fault injection
  function automatic logic [3:0] gate(input int mode, input logic [3:0] ga,
                                      input logic [3:0] gb, input logic [3:0] c);
    case (mode)
      1: gate = ga & gb;
      2: gate = 4'h0;
      3: gate = 4'hf;
      4: gate = (ga | gb) ^ c;
      5: gate = (ga | gb) & 4'b1101;
      default: gate = ga | gb;
    endcase
  endfunction

  logic [3:0] g1, g2;
  always_comb begin
    g1 = gate(mode1, {3'b0, a1}, {3'b0, b1}, corrupt[{6'b0, a1, b1}]);
    g2 = gate(mode2, {2'b0, a2}, {2'b0, b2}, corrupt[{4'b0, a2, b2}]);
    y1 = g1[0];
    y2 = g2[1:0];
  end

  logic [31:0] oa, ob, obusy, odone, opass, oerr, off;
  always_comb begin
    if (cur_sel == 2) begin
      oa = 32'(a2); ob = 32'(b2); obusy = 32'(busy2); odone = 32'(done2);
      opass = 32'(pass2); oerr = 32'(err2); off = 32'(ff2);
    end else begin
      oa = 32'(a1); ob = 32'(b1); obusy = 32'(busy1); odone = 32'(done1);
      opass = 32'(pass1); oerr = 32'(err1); off = 32'(ff1);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel == 2) start2 = v;
    else start1 = v;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a"}, oa, 0);
    chk({tag, "_b"}, ob, 0);
    chk({tag, "_busy"}, obusy, 0);
    chk({tag, "_done"}, odone, 0);
    chk({tag, "_pass"}, opass, 0);
    chk({tag, "_err"}, oerr, 0);
    chk({tag, "_ff"}, off, 0);
  endtask

  // one run; vector k/(s+1) is expected on a/b in cycle k after the start edge
  task automatic run(input string tag, input int sel, input int w, input int s,
                     input int exp_err, input int exp_ff, input bit poke,
                     input int abort_at);
    int n;
    int len;
    int vec;
    n = 1 << (2 * w);
    len = n * (s + 1);
    cur_sel = sel;
    set_start(sel, 1'b1);
    @(posedge clk); #1;
    set_start(sel, 1'b0);
    for (int k = 0; k < len; k++) begin
      vec = k / (s + 1);
      chk({tag, "_a"}, oa, vec >> w);
      chk({tag, "_b"}, ob, vec % (1 << w));
      chk({tag, "_busy"}, obusy, 1);
      chk({tag, "_done_early"}, odone, 0);
      set_start(sel, poke && k == 2);
      if (k == abort_at) reset = 1'b1;
      @(posedge clk); #1;
      set_start(sel, 1'b0);
      if (k == abort_at) begin
        reset = 1'b0;
        chk_zero({tag, "_abort"});
        return;
      end
    end
    chk({tag, "_done"}, odone, 1);
    chk({tag, "_busy_done"}, obusy, 0);
    chk({tag, "_a_done"}, oa, 0);
    chk({tag, "_err_done"}, oerr, exp_err);
    set_start(sel, poke);
    @(posedge clk); #1;
    set_start(sel, 1'b0);
    chk({tag, "_done_after"}, odone, 0);
    chk({tag, "_busy_after"}, obusy, 0);
    chk({tag, "_pass"}, opass, (exp_err == 0) ? 1 : 0);
    chk({tag, "_err"}, oerr, exp_err);
    if (exp_err != 0) chk({tag, "_ff"}, off, exp_ff);
    @(posedge clk); #1;
    chk({tag, "_idle_busy"}, obusy, 0);
    chk({tag, "_idle_done"}, odone, 0);
  endtask

  task automatic rand_run(input string tag, input int sel, input int w, input int s);
    int n;
    int e;
    int f;
    n = 1 << (2 * w);
    e = 0;
    f = -1;
    for (int i = 0; i < 256; i++) corrupt[i] = 4'h0;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        corrupt[i] = 4'($urandom_range(1, (1 << w) - 1));
        e++;
        if (f < 0) f = i;
      end
    end
    if (sel == 2) mode2 = 4;
    else mode1 = 4;
    run(tag, sel, w, s, e, (f < 0) ? 0 : f, 1'b0, -1);
    mode1 = 0;
    mode2 = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) corrupt[i] = 4'h0;
    reset = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      cur_sel = 1; chk_zero("rst1");
      cur_sel = 2; chk_zero("rst2");
    end
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("idle_busy1", 32'(busy1), 0);
      chk("idle_busy2", 32'(busy2), 0);
    end

    run("ok1", 1, 1, 1, 0, 0, 1'b0, -1);
    mode1 = 1; run("and1", 1, 1, 1, 2, 1, 1'b0, -1);
    mode1 = 2; run("st0", 1, 1, 1, 3, 1, 1'b0, -1);
    mode1 = 3; run("st1", 1, 1, 1, 1, 0, 1'b0, -1);
    mode1 = 0;
    run("poke", 1, 1, 1, 0, 0, 1'b1, -1);
    run("abort", 1, 1, 1, 0, 0, 1'b0, 4);
    run("rerun", 1, 1, 1, 0, 0, 1'b0, -1);

    run("ok2", 2, 2, 3, 0, 0, 1'b0, -1);
    mode2 = 5; run("bit1", 2, 2, 3, 12, 2, 1'b0, -1);
    mode2 = 0;

    for (int r = 0; r < 4; r++) rand_run("rnd1", 1, 1, 1);
    for (int r = 0; r < 4; r++) rand_run("rnd2", 2, 2, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
